// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache refill sequencer.
package cache_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RECV = 2'd2
  } state_e;

  // Clear the word-offset and byte-offset bits so the address points at the line start.
  function automatic logic [WORD_W-1:0] line_base(input logic [WORD_W-1:0] addr,
                                                  input int idx_w);
    logic [WORD_W-1:0] mask;
    mask = (32'd1 << (idx_w + 2)) - 32'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/refill_beat_cnt.sv
// Line-offset counter for a refill: loads the start index, advances modulo
// LINE_WORDS on each accepted beat and flags the final beat of the line.
module refill_beat_cnt
  import cache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_load,
  input  logic [IDX_W-1:0] i_start_idx,
  input  logic             i_inc,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_last
);

  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_beat;

  // Index and beat count; index wraps naturally since LINE_WORDS is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_idx  <= {IDX_W{1'b0}};
      r_beat <= {IDX_W{1'b0}};
    end else if (i_load) begin
      r_idx  <= i_start_idx;
      r_beat <= {IDX_W{1'b0}};
    end else if (i_inc) begin
      r_idx  <= r_idx + IDX_W'(1);
      r_beat <= r_beat + IDX_W'(1);
    end else begin
      r_idx  <= r_idx;
      r_beat <= r_beat;
    end
  end

  assign o_idx  = r_idx;
  assign o_last = (r_beat == LAST_BEAT);

endmodule

// File: rtl/cache_refill_seq.sv
// Cache-line refill sequencer: accepts a miss, issues one burst read and
// streams the returned words to the cache data-in mux.
// Optional critical-word-first ordering: define CACHE_REFILL_CWF_EN.
module cache_refill_seq
  import cache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              miss_req,
  input  logic [WORD_W-1:0] miss_addr,
  output logic              miss_ack,
  output logic              mem_rd_req,
  output logic [WORD_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ready,
  input  logic              mem_rd_valid,
  input  logic [WORD_W-1:0] mem_rd_data,
  output logic [WORD_W-1:0] refill_data,
  output logic              refill_valid_seq,
  output logic [IDX_W-1:0]  refill_word_idx,
  output logic              refill_done,
  output logic              busy
);

  state_e            r_state, w_next_state;
  logic              r_miss_ack, w_ack_nxt;
  logic              r_mem_rd_req, w_req_nxt;
  logic [WORD_W-1:0] r_mem_rd_addr, w_addr_nxt;
  logic [WORD_W-1:0] r_refill_data, w_data_nxt;
  logic              r_refill_valid, w_valid_nxt;
  logic [IDX_W-1:0]  r_refill_idx, w_idx_nxt;
  logic              r_refill_done, w_done_nxt;
  logic              r_busy;
  logic              w_load, w_inc;
  logic [IDX_W-1:0]  w_start_idx, w_cnt_idx;
  logic              w_cnt_last;
  logic [WORD_W-1:0] w_req_addr;

`ifdef CACHE_REFILL_CWF_EN
  assign w_start_idx = miss_addr[IDX_W+1:2];
  assign w_req_addr  = line_base(miss_addr, IDX_W)
                     | {{(WORD_W-IDX_W-2){1'b0}}, w_start_idx, 2'b00};
`else
  assign w_start_idx = {IDX_W{1'b0}};
  assign w_req_addr  = line_base(miss_addr, IDX_W);
`endif

  refill_beat_cnt #(
    .LINE_WORDS (LINE_WORDS),
    .IDX_W      (IDX_W)
  ) u_beat_cnt (
    .clk         (clk),
    .resetn      (resetn),
    .i_load      (w_load),
    .i_start_idx (w_start_idx),
    .i_inc       (w_inc),
    .o_idx       (w_cnt_idx),
    .o_last      (w_cnt_last)
  );

  // Next-state and next-output decode; REQ first raises the request, then waits for ready.
  always_comb begin
    w_next_state = r_state;
    w_ack_nxt    = 1'b0;
    w_req_nxt    = r_mem_rd_req;
    w_addr_nxt   = r_mem_rd_addr;
    w_data_nxt   = r_refill_data;
    w_valid_nxt  = 1'b0;
    w_idx_nxt    = r_refill_idx;
    w_done_nxt   = 1'b0;
    w_load       = 1'b0;
    w_inc        = 1'b0;
    case (r_state)
      IDLE: begin
        if (miss_req) begin
          w_load       = 1'b1;
          w_ack_nxt    = 1'b1;
          w_addr_nxt   = w_req_addr;
          w_next_state = REQ;
        end else begin
          w_next_state = IDLE;
        end
      end
      REQ: begin
        if (!r_mem_rd_req) begin
          w_req_nxt = 1'b1;
        end else if (mem_rd_ready) begin
          w_req_nxt    = 1'b0;
          w_next_state = RECV;
        end else begin
          w_req_nxt = 1'b1;
        end
      end
      RECV: begin
        if (mem_rd_valid) begin
          w_inc       = 1'b1;
          w_valid_nxt = 1'b1;
          w_data_nxt  = mem_rd_data;
          w_idx_nxt   = w_cnt_idx;
          if (w_cnt_last) begin
            w_done_nxt   = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_next_state = RECV;
          end
        end else begin
          w_next_state = RECV;
        end
      end
      default: begin
        w_req_nxt    = 1'b0;
        w_next_state = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any refill without pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= IDLE;
      r_miss_ack     <= 1'b0;
      r_mem_rd_req   <= 1'b0;
      r_mem_rd_addr  <= {WORD_W{1'b0}};
      r_refill_data  <= {WORD_W{1'b0}};
      r_refill_valid <= 1'b0;
      r_refill_idx   <= {IDX_W{1'b0}};
      r_refill_done  <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_miss_ack     <= w_ack_nxt;
      r_mem_rd_req   <= w_req_nxt;
      r_mem_rd_addr  <= w_addr_nxt;
      r_refill_data  <= w_data_nxt;
      r_refill_valid <= w_valid_nxt;
      r_refill_idx   <= w_idx_nxt;
      r_refill_done  <= w_done_nxt;
      r_busy         <= (w_next_state != IDLE);
    end
  end

  assign miss_ack         = r_miss_ack;
  assign mem_rd_req       = r_mem_rd_req;
  assign mem_rd_addr      = r_mem_rd_addr;
  assign refill_data      = r_refill_data;
  assign refill_valid_seq = r_refill_valid;
  assign refill_word_idx  = r_refill_idx;
  assign refill_done      = r_refill_done;
  assign busy             = r_busy;

endmodule

// File: tb/tb_cache_refill_seq.sv
// Directed bench for cache_refill_seq (LINE_WORDS=4): a vector table for the
// basic refill plus hand sequences for stalls, reset abort and back-to-back misses.
module tb_cache_refill_seq;

  localparam int LW = 4;
  localparam int IW = 2;

`ifdef CACHE_REFILL_CWF_EN
  localparam logic [31:0] A1 = 32'h0000_1238, E1 = 32'h0000_1238;
  localparam int          S1 = 2;
  localparam logic [31:0] A2 = 32'h0000_2004, E2 = 32'h0000_2004;
  localparam int          S2 = 1;
  localparam logic [31:0] A3 = 32'h0000_4008, E3 = 32'h0000_4008;
  localparam int          S3 = 2;
  localparam logic [31:0] A4 = 32'h0000_3ABC, E4 = 32'h0000_3ABC;
  localparam int          S4 = 3;
`else
  localparam logic [31:0] A1 = 32'h0000_1234, E1 = 32'h0000_1230;
  localparam int          S1 = 0;
  localparam logic [31:0] A2 = 32'h0000_2004, E2 = 32'h0000_2000;
  localparam int          S2 = 0;
  localparam logic [31:0] A3 = 32'h0000_4008, E3 = 32'h0000_4000;
  localparam int          S3 = 0;
  localparam logic [31:0] A4 = 32'h0000_3ABC, E4 = 32'h0000_3AB0;
  localparam int          S4 = 0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          miss_req = 1'b0;
  logic [31:0]   miss_addr = 32'h0;
  logic          mem_rd_ready = 1'b0;
  logic          mem_rd_valid = 1'b0;
  logic [31:0]   mem_rd_data = 32'h0;
  logic          miss_ack, mem_rd_req, refill_valid_seq, refill_done, busy;
  logic [31:0]   mem_rd_addr, refill_data;
  logic [IW-1:0] refill_word_idx;

  always #5 clk = ~clk;

  cache_refill_seq #(.LINE_WORDS(LW)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .miss_req         (miss_req),
    .miss_addr        (miss_addr),
    .miss_ack         (miss_ack),
    .mem_rd_req       (mem_rd_req),
    .mem_rd_addr      (mem_rd_addr),
    .mem_rd_ready     (mem_rd_ready),
    .mem_rd_valid     (mem_rd_valid),
    .mem_rd_data      (mem_rd_data),
    .refill_data      (refill_data),
    .refill_valid_seq (refill_valid_seq),
    .refill_word_idx  (refill_word_idx),
    .refill_done      (refill_done),
    .busy             (busy)
  );

  typedef struct {
    logic        mreq;
    logic [31:0] maddr;
    logic        rdy;
    logic        vld;
    logic [31:0] rdata;
    logic        ack;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] d;
    logic [1:0]  idx;
    logic        done;
    logic        b;
  } vec_t;

  vec_t tbl[8];
  int   n_vec = 0;
  int   n_fail = 0;

  function automatic logic [1:0] ix(input int s, input int k);
    return 2'((s + k) % LW);
  endfunction

  function automatic vec_t mkv(input logic mreq, input logic [31:0] maddr, input logic rdy,
                               input logic vld, input logic [31:0] rdata, input logic ack,
                               input logic req, input logic [31:0] addr, input logic v,
                               input logic [31:0] d, input logic [1:0] idx, input logic done,
                               input logic b);
    vec_t r;
    r.mreq = mreq; r.maddr = maddr; r.rdy = rdy; r.vld = vld; r.rdata = rdata;
    r.ack = ack; r.req = req; r.addr = addr; r.v = v; r.d = d; r.idx = idx;
    r.done = done; r.b = b;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ack, input logic req,
                         input logic [31:0] addr, input logic v, input logic [31:0] d,
                         input logic [1:0] idx, input logic done, input logic b);
    chk({tag, ".miss_ack"}, 32'(miss_ack), 32'(ack));
    chk({tag, ".mem_rd_req"}, 32'(mem_rd_req), 32'(req));
    chk({tag, ".mem_rd_addr"}, mem_rd_addr, addr);
    chk({tag, ".valid"}, 32'(refill_valid_seq), 32'(v));
    chk({tag, ".data"}, refill_data, d);
    chk({tag, ".idx"}, 32'(refill_word_idx), 32'(idx));
    chk({tag, ".done"}, 32'(refill_done), 32'(done));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From the REQ state: request phase, ready handshake, then LW back-to-back beats.
  task automatic refill_tail(input string tag, input logic [31:0] ea, input int s,
                             input logic [31:0] dbase, input logic hold);
    miss_req = hold; mem_rd_ready = 1'b1; mem_rd_valid = 1'b0;
    step();
    chk({tag, ".req_up"}, 32'(mem_rd_req), 32'd1);
    chk({tag, ".req_addr"}, mem_rd_addr, ea);
    step();
    chk({tag, ".req_down"}, 32'(mem_rd_req), 32'd0);
    mem_rd_ready = 1'b0;
    for (int k = 0; k < LW; k++) begin
      mem_rd_valid = 1'b1; mem_rd_data = dbase + 32'(k);
      step();
      chk_out($sformatf("%s.beat%0d", tag, k), 1'b0, 1'b0, ea, 1'b1, dbase + 32'(k),
              ix(s, k), (k == LW - 1), (k != LW - 1));
    end
    mem_rd_valid = 1'b0;
  endtask

  task automatic refill_full(input string tag, input logic [31:0] a, input logic [31:0] ea,
                             input int s, input logic [31:0] dbase, input logic hold);
    miss_req = 1'b1; miss_addr = a; mem_rd_valid = 1'b0;
    step();
    chk({tag, ".ack"}, 32'(miss_ack), 32'd1);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    refill_tail(tag, ea, s, dbase, hold);
  endtask

  initial begin
    logic [31:0] last_d;
    logic        pat[8];
    int          k;

    tbl[0] = mkv(1, A1, 1, 0, 32'h0,          1, 0, E1, 0, 32'h0,          2'd0,      0, 1);
    tbl[1] = mkv(0, A1, 1, 1, 32'hBAD0_0001,  0, 1, E1, 0, 32'h0,          2'd0,      0, 1);
    tbl[2] = mkv(0, A1, 1, 1, 32'hBAD0_0002,  0, 0, E1, 0, 32'h0,          2'd0,      0, 1);
    tbl[3] = mkv(0, A1, 0, 1, 32'hC0DE_0000,  0, 0, E1, 1, 32'hC0DE_0000,  ix(S1, 0), 0, 1);
    tbl[4] = mkv(0, A1, 0, 1, 32'hC0DE_0001,  0, 0, E1, 1, 32'hC0DE_0001,  ix(S1, 1), 0, 1);
    tbl[5] = mkv(0, A1, 0, 1, 32'hC0DE_0002,  0, 0, E1, 1, 32'hC0DE_0002,  ix(S1, 2), 0, 1);
    tbl[6] = mkv(0, A1, 0, 1, 32'hC0DE_0003,  0, 0, E1, 1, 32'hC0DE_0003,  ix(S1, 3), 1, 0);
    tbl[7] = mkv(0, A1, 0, 1, 32'hBAD0_0003,  0, 0, E1, 0, 32'hC0DE_0003,  ix(S1, 3), 0, 0);

    // Reset state.
    #12;
    chk_out("reset", 0, 0, 32'h0, 0, 32'h0, 2'd0, 0, 0);
    step();
    resetn = 1'b1;

    // Basic refill from the vector table (stray beats in REQ and IDLE included).
    for (int i = 0; i < 8; i++) begin
      miss_req = tbl[i].mreq; miss_addr = tbl[i].maddr; mem_rd_ready = tbl[i].rdy;
      mem_rd_valid = tbl[i].vld; mem_rd_data = tbl[i].rdata;
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].ack, tbl[i].req, tbl[i].addr, tbl[i].v,
              tbl[i].d, tbl[i].idx, tbl[i].done, tbl[i].b);
    end

    // Memory stall: ready withheld 5 cycles, gaps between beats.
    miss_req = 1'b1; miss_addr = A2; mem_rd_ready = 1'b0; mem_rd_valid = 1'b0;
    step();
    chk("stall.ack", 32'(miss_ack), 32'd1);
    miss_req = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("stall.req%0d", c), 32'(mem_rd_req), 32'd1);
      chk($sformatf("stall.addr%0d", c), mem_rd_addr, E2);
    end
    mem_rd_ready = 1'b1;
    step();
    chk("stall.req_down", 32'(mem_rd_req), 32'd0);
    mem_rd_ready = 1'b0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    last_d = 32'hC0DE_0003;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      mem_rd_valid = pat[c];
      mem_rd_data = pat[c] ? (32'hA5A5_0000 + 32'(k)) : 32'hFFFF_FFFF;
      step();
      if (pat[c]) begin
        last_d = 32'hA5A5_0000 + 32'(k);
        chk_out($sformatf("stall.beat%0d", k), 0, 0, E2, 1, last_d, ix(S2, k),
                (k == LW - 1), (k != LW - 1));
        k++;
      end else begin
        chk($sformatf("stall.gapv%0d", c), 32'(refill_valid_seq), 32'd0);
        chk($sformatf("stall.gapd%0d", c), refill_data, last_d);
      end
    end
    mem_rd_valid = 1'b0;

    // Reset in the middle of a refill, after two beats.
    miss_req = 1'b1; miss_addr = A1;
    step();
    miss_req = 1'b0;
    step();
    mem_rd_ready = 1'b1;
    step();
    mem_rd_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_rd_valid = 1'b1; mem_rd_data = 32'h5151_0000 + 32'(b);
      step();
      chk($sformatf("abort.beat%0d", b), refill_data, 32'h5151_0000 + 32'(b));
    end
    mem_rd_data = 32'hBAD0_0010;
    #2;
    resetn = 1'b0;
    #1;
    chk_out("abort.async", 0, 0, 32'h0, 0, 32'h0, 2'd0, 0, 0);
    step();
    chk_out("abort.held", 0, 0, 32'h0, 0, 32'h0, 2'd0, 0, 0);
    resetn = 1'b1;
    for (int b = 0; b < 2; b++) begin
      step();
      chk($sformatf("abort.late_v%0d", b), 32'(refill_valid_seq), 32'd0);
      chk($sformatf("abort.late_done%0d", b), 32'(refill_done), 32'd0);
      chk($sformatf("abort.late_busy%0d", b), 32'(busy), 32'd0);
    end
    mem_rd_valid = 1'b0;
    refill_full("post_rst", A1, E1, S1, 32'h7777_0000, 1'b0);

    // Back-to-back misses with miss_req held high.
    refill_full("b2b1", A3, E3, S3, 32'h1111_0000, 1'b1);
    miss_addr = A4;
    step();
    chk("b2b.ack2", 32'(miss_ack), 32'd1);
    chk("b2b.busy_back", 32'(busy), 32'd1);
    chk("b2b.no_done", 32'(refill_done), 32'd0);
    refill_tail("b2b2", E4, S4, 32'h2222_0000, 1'b0);
    step();
    chk("end.busy", 32'(busy), 32'd0);
    chk("end.ack", 32'(miss_ack), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_refill_seq.md
Name: cache_refill_seq

Overview:
- Sequences a cache-line refill after a miss: issues one burst read to memory, collects LINE_WORDS returned 32-bit words, and streams them downstream.
- Its refill_data / refill_valid_seq outputs feed the cache data-in 2:1 word mux: select=1 picks the refill word, select=0 picks the CPU store word.
- Sits between the cache miss detector and the memory interface.

Parameters:
- LINE_WORDS, 4, words per cache line; power of two, 2..16.
- IDX_W, $clog2(LINE_WORDS), word-index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- miss_req  in  1  refill request, level; sampled in IDLE only.
- miss_addr  in  32  byte address of missing access.
- miss_ack  out  1  one-cycle pulse: request accepted.
- mem_rd_req  out  1  burst read request; held until mem_rd_ready.
- mem_rd_addr  out  32  burst start byte address.
- mem_rd_ready  in  1  memory accepts request this cycle.
- mem_rd_valid  in  1  one returned word valid this cycle.
- mem_rd_data  in  32  returned word.
- refill_data  out  32  registered word to data-in mux.
- refill_valid_seq  out  1  mux select; 1 for exactly one cycle per refill word.
- refill_word_idx  out  IDX_W  line offset of refill_data.
- refill_done  out  1  one-cycle pulse coincident with last word.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Reset asserted mid-refill aborts immediately. No pulse is emitted. Late mem_rd_valid beats after reset release are ignored in IDLE.
- IDLE:
  - miss_req=1: latch line base = miss_addr with bits [IDX_W+1:0] cleared.
  - Latch start index, pulse miss_ack, go REQ next cycle.
- REQ:
  - mem_rd_req=1 and mem_rd_addr stable until the cycle mem_rd_ready=1, then go RECV.
  - mem_rd_valid in REQ is ignored.
- RECV: on each mem_rd_valid cycle, the next cycle has:
  - refill_data=mem_rd_data
  - refill_valid_seq=1
  - refill_word_idx=current index
  - Index increments modulo LINE_WORDS (wrap-around); the beat counter increments.
  - No mem_rd_valid means refill_valid_seq=0; refill_data holds its previous value.
  - Beat LINE_WORDS-1 also pulses refill_done in the same output cycle, then goes IDLE.
- Latency: mem_rd_valid beat to refill_valid_seq is 1 cycle; miss_req to mem_rd_req is 2 cycles (IDLE→REQ).
- Back-to-back: miss_req held high through refill_done is accepted on the first IDLE cycle after it. busy falls for exactly that one cycle.
- Simultaneous mem_rd_valid and last beat: handled as a normal last beat; extra beats beyond LINE_WORDS are ignored.
- Byte offset bits [1:0] of miss_addr are ignored everywhere.

Optional Feature:
- Macro CACHE_REFILL_CWF_EN (critical word first).
- Defined:
  - Start index = miss_addr[IDX_W+1:2].
  - mem_rd_addr = base + start index×4; memory returns words in wrapped order.
  - refill_word_idx begins at start index and wraps modulo LINE_WORDS.
- Undefined:
  - Start index is always 0; mem_rd_addr = line base.
  - Indices run 0..LINE_WORDS-1.

Decomposition:
- Shared package cache_pkg:
  - state enum {IDLE, REQ, RECV}
  - WORD_W=32
  - line-base mask function
- Sub-module refill_beat_cnt (modulo index counter plus last-beat flag). It is natural and small.
- Everything else lives in the top module.

Test Plan:
- Basic refill, CWF off, miss_addr=0x0000_1234, ready the same cycle, data D0..D3 on consecutive cycles:
  - mem_rd_addr=0x0000_1230.
  - refill_word_idx 0,1,2,3 with refill_valid_seq high 4 cycles.
  - refill_done on idx 3.
- CWF on, miss_addr=0x0000_1238:
  - mem_rd_addr=0x0000_1238.
  - Indices 2,3,0,1.
  - refill_done coincident with idx 1.
- Memory stalls: mem_rd_ready delayed 5 cycles, gaps between valid beats:
  - mem_rd_req and mem_rd_addr are stable during the delay.
  - refill_valid_seq is low in gaps; refill_data is held.
- Reset mid-refill: resetn=0 after 2 beats:
  - All outputs 0 asynchronously; no refill_done.
  - Next miss refills all 4 words correctly.
- Back-to-back misses, miss_req held high:
  - Second miss_ack exactly 1 cycle after the first refill_done.
  - busy low for exactly 1 cycle.
- Stray beats: mem_rd_valid pulsed in IDLE and REQ:
  - No refill_valid_seq.
  - Beat count unaffected.
